cgra_launch_ctrl: RTL and testbench
===================================

CGRA_LAUNCH_CTRL -- requirements
Module: cgra_launch_ctrl

Interface
REQ-001 Parameters SHALL be: SYS_DWIDTH, 32, data/address width | BYTE_LEN, 4, byte-enable width | LEN_W, 16, word-count width | TIMEOUT, 65535, maximum cycles spent waiting on each Computation_Done edge.
REQ-002 Clk  in  1  single clock; all logic rising-edge.
REQ-003 Rst  in  1  reset, synchronous, active-high.
REQ-004 Launch_Valid  in  1  launch request; Launch_Ready  out  1  high only in IDLE.
REQ-005 Launch_In_Base, Launch_Out_Base  in  SYS_DWIDTH  byte base addresses of input and result regions.
REQ-006 Launch_In_Len, Launch_Out_Len  in  LEN_W  word counts to load and to read back.
REQ-007 In_Data  in  SYS_DWIDTH, In_Data_Valid  in  1, In_Data_Ready  out  1  input word stream.
REQ-008 Out_Data  out  SYS_DWIDTH, Out_Data_Valid  out  1, Out_Data_Ready  in  1  result word stream.
REQ-009 Bram_En  out  1, Bram_Wen  out  BYTE_LEN, Bram_Addr  out  SYS_DWIDTH, Bram_Data_To_Bram  out  SYS_DWIDTH, Bram_Data_From_Bram  in  SYS_DWIDTH  BRAM master port.
REQ-010 Computation_Start  out  1, Computation_Done  in  1  the kernel-launch handshake, driven from the initiator side.
REQ-011 Busy  out  1  high in any non-IDLE state; Error  out  1  one-cycle pulse on timeout; Launch_Done  out  1  one-cycle pulse on normal completion.

Function
REQ-012 The state machine SHALL have the states IDLE, LOAD, START, WAIT_DONE, WAIT_CLR, RD_ISSUE, RD_CAPT, DRAIN.
REQ-013 IDLE: on Launch_Valid, latch bases and lengths, zero the word counter, and go to LOAD (or START if Launch_In_Len==0).
REQ-014 LOAD: In_Data_Ready=1; on each In_Data_Valid&&In_Data_Ready cycle, drive Bram_En=1, Bram_Wen=all ones, Bram_Addr=In_Base+4*cnt, Bram_Data_To_Bram=In_Data, increment cnt; after the last word, go to START.
REQ-015 Bram_En/Bram_Wen SHALL be zero in every cycle with no transfer; no BRAM write SHALL occur outside LOAD.
REQ-016 START: assert Computation_Start, load the timeout counter, and go to WAIT_DONE.
REQ-017 WAIT_DONE: hold Computation_Start=1 until Computation_Done==1, then drop Computation_Start next cycle and go to WAIT_CLR.
REQ-018 WAIT_CLR: hold Computation_Start=0 until Computation_Done==0, then go to RD_ISSUE (or finish if Launch_Out_Len==0).
REQ-019 If Computation_Done is already high on entry to START, the block SHALL still assert Start and proceed through WAIT_DONE immediately (one-cycle Start pulse minimum).
REQ-020 Timeout: in WAIT_DONE or WAIT_CLR, when the counter reaches TIMEOUT without the awaited edge, set Computation_Start=0, pulse Error, and return to IDLE without reading results.
REQ-021 RD_ISSUE: Bram_En=1, Bram_Wen=0, Bram_Addr=Out_Base+4*cnt; next state RD_CAPT (BRAM read latency = 1 cycle).
REQ-022 RD_CAPT: register Bram_Data_From_Bram into Out_Data, set Out_Data_Valid=1, and go to DRAIN.
REQ-023 DRAIN: hold Out_Data and Out_Data_Valid stable until Out_Data_Ready; on the handshake, increment cnt and go to RD_ISSUE, or, after the last word, pulse Launch_Done and go to IDLE.
REQ-024 Address arithmetic SHALL be modulo 2^SYS_DWIDTH; wrap-around is silent.
REQ-025 Launch_Valid outside IDLE SHALL be ignored; parameters SHALL NOT change mid-launch.

Reset
REQ-026 When Rst=1 at a clock edge, the block SHALL enter IDLE, clear all counters, and drive all outputs to 0 except Launch_Ready=1.
REQ-027 Reset mid-operation (any state) SHALL drop Computation_Start and Out_Data_Valid in the following cycle, with no further BRAM accesses.

Verification
REQ-028 Launch In_Base=0x100, In_Len=3, Out_Len=0, data A,B,C -> writes to 0x100/0x104/0x108, Start high, Done model responds after 5 cycles, Start falls, Done falls, Launch_Done pulse.
REQ-029 Full launch with Out_Base=0x200, Out_Len=2, BRAM holding X,Y -> Out_Data X then Y; with Out_Data_Ready held low 4 cycles, Out_Data stays X, stable.
REQ-030 Done never asserted, TIMEOUT=16 -> Error pulse 16 cycles after WAIT_DONE entry, Start=0, back in IDLE, no reads.
REQ-031 In_Len=0, Out_Len=0 -> no BRAM activity, handshake only, Launch_Done.
REQ-032 Rst asserted during WAIT_DONE -> Start=0 next cycle, Launch_Ready=1, and a subsequent launch completes normally.
REQ-033 In_Base=0xFFFFFFFC, In_Len=2 -> write addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/cgra_launch_ctrl.sv
// Kernel launch controller: copies input words into BRAM, runs the Start/Done
// handshake with a timeout, then streams result words back out of BRAM.
module cgra_launch_ctrl #(
   parameter int unsigned SYS_DWIDTH = 32,
   parameter int unsigned BYTE_LEN   = 4,
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned TIMEOUT    = 65535
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Launch_Valid,
   output logic                  Launch_Ready,
   input  logic [SYS_DWIDTH-1:0] Launch_In_Base,
   input  logic [SYS_DWIDTH-1:0] Launch_Out_Base,
   input  logic [LEN_W-1:0]      Launch_In_Len,
   input  logic [LEN_W-1:0]      Launch_Out_Len,
   input  logic [SYS_DWIDTH-1:0] In_Data,
   input  logic                  In_Data_Valid,
   output logic                  In_Data_Ready,
   output logic [SYS_DWIDTH-1:0] Out_Data,
   output logic                  Out_Data_Valid,
   input  logic                  Out_Data_Ready,
   output logic                  Bram_En,
   output logic [BYTE_LEN-1:0]   Bram_Wen,
   output logic [SYS_DWIDTH-1:0] Bram_Addr,
   output logic [SYS_DWIDTH-1:0] Bram_Data_To_Bram,
   input  logic [SYS_DWIDTH-1:0] Bram_Data_From_Bram,
   output logic                  Computation_Start,
   input  logic                  Computation_Done,
   output logic                  Busy,
   output logic                  Error,
   output logic                  Launch_Done
);

   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle, StLoad, StStart, StWaitDone, StWaitClr, StRdIssue, StRdCapt, StDrain
   } state_e;

   state_e                state_q, state_d;
   logic [SYS_DWIDTH-1:0] in_base_q, in_base_d;
   logic [SYS_DWIDTH-1:0] out_base_q, out_base_d;
   logic [LEN_W-1:0]      in_len_q, in_len_d;
   logic [LEN_W-1:0]      out_len_q, out_len_d;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic [TmoW-1:0]       tmo_q, tmo_d;
   logic [SYS_DWIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;

   logic [SYS_DWIDTH-1:0] cnt_off;
   logic                  last_in, last_out, tmo_hit;

   // Word index to byte offset; the base add wraps silently.
   assign cnt_off  = SYS_DWIDTH'(cnt_q) << 2;
   assign last_in  = (cnt_q == in_len_q - LEN_W'(1));
   assign last_out = (cnt_q == out_len_q - LEN_W'(1));
   assign tmo_hit  = (tmo_q == TmoW'(TIMEOUT));

   assign Out_Data       = out_data_q;
   assign Out_Data_Valid = out_valid_q;
   assign Busy           = (state_q != StIdle);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= StIdle;
         in_base_q   <= '0;
         out_base_q  <= '0;
         in_len_q    <= '0;
         out_len_q   <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_base_q   <= in_base_d;
         out_base_q  <= out_base_d;
         in_len_q    <= in_len_d;
         out_len_q   <= out_len_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      in_base_d         = in_base_q;
      out_base_d        = out_base_q;
      in_len_d          = in_len_q;
      out_len_d         = out_len_q;
      cnt_d             = cnt_q;
      tmo_d             = tmo_q;
      out_data_d        = out_data_q;
      out_valid_d       = out_valid_q;
      Launch_Ready      = 1'b0;
      In_Data_Ready     = 1'b0;
      Bram_En           = 1'b0;
      Bram_Wen          = '0;
      Bram_Addr         = '0;
      Bram_Data_To_Bram = '0;
      Computation_Start = 1'b0;
      Error             = 1'b0;
      Launch_Done       = 1'b0;

      unique case (state_q)
         StIdle: begin
            Launch_Ready = 1'b1;
            if (Launch_Valid) begin
               in_base_d  = Launch_In_Base;
               out_base_d = Launch_Out_Base;
               in_len_d   = Launch_In_Len;
               out_len_d  = Launch_Out_Len;
               cnt_d      = '0;
               state_d    = (Launch_In_Len == '0) ? StStart : StLoad;
            end
         end
         StLoad: begin
            In_Data_Ready = 1'b1;
            if (In_Data_Valid) begin
               Bram_En           = 1'b1;
               Bram_Wen          = '1;
               Bram_Addr         = in_base_q + cnt_off;
               Bram_Data_To_Bram = In_Data;
               cnt_d             = cnt_q + LEN_W'(1);
               if (last_in) state_d = StStart;
            end
         end
         StStart: begin
            Computation_Start = 1'b1;
            tmo_d             = '0;
            state_d           = StWaitDone;
         end
         StWaitDone: begin
            // An arriving Done wins over a coincident timeout.
            if (Computation_Done) begin
               Computation_Start = 1'b1;
               tmo_d             = '0;
               state_d           = StWaitClr;
            end else if (tmo_hit) begin
               Error   = 1'b1;
               state_d = StIdle;
            end else begin
               Computation_Start = 1'b1;
               tmo_d             = tmo_q + TmoW'(1);
            end
         end
         StWaitClr: begin
            if (!Computation_Done) begin
               cnt_d = '0;
               if (out_len_q == '0) begin
                  Launch_Done = 1'b1;
                  state_d     = StIdle;
               end else begin
                  state_d = StRdIssue;
               end
            end else if (tmo_hit) begin
               Error   = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StRdIssue: begin
            Bram_En   = 1'b1;
            Bram_Addr = out_base_q + cnt_off;
            state_d   = StRdCapt;
         end
         StRdCapt: begin
            out_data_d  = Bram_Data_From_Bram;
            out_valid_d = 1'b1;
            state_d     = StDrain;
         end
         StDrain: begin
            if (Out_Data_Ready) begin
               out_valid_d = 1'b0;
               if (last_out) begin
                  Launch_Done = 1'b1;
                  state_d     = StIdle;
               end else begin
                  cnt_d   = cnt_q + LEN_W'(1);
                  state_d = StRdIssue;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_cgra_launch_ctrl.sv
// Self-checking bench for cgra_launch_ctrl: BRAM and Done responder models plus
// per-scenario tasks comparing logged traffic against spec-derived expectations.
module tb_cgra_launch_ctrl;
   localparam int unsigned DW  = 32;
   localparam int unsigned BL  = 4;
   localparam int unsigned LW  = 16;
   localparam int unsigned TMO = 16;

   logic          Clk;
   logic          Rst;
   logic          Launch_Valid, Launch_Ready;
   logic [DW-1:0] Launch_In_Base, Launch_Out_Base;
   logic [LW-1:0] Launch_In_Len, Launch_Out_Len;
   logic [DW-1:0] In_Data;
   logic          In_Data_Valid, In_Data_Ready;
   logic [DW-1:0] Out_Data;
   logic          Out_Data_Valid, Out_Data_Ready;
   logic          Bram_En;
   logic [BL-1:0] Bram_Wen;
   logic [DW-1:0] Bram_Addr, Bram_Data_To_Bram, Bram_Data_From_Bram;
   logic          Computation_Start, Computation_Done;
   logic          Busy, Error, Launch_Done;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   cgra_launch_ctrl #(
      .SYS_DWIDTH(DW), .BYTE_LEN(BL), .LEN_W(LW), .TIMEOUT(TMO)
   ) dut (
      .Clk                 (Clk),
      .Rst                 (Rst),
      .Launch_Valid        (Launch_Valid),
      .Launch_Ready        (Launch_Ready),
      .Launch_In_Base      (Launch_In_Base),
      .Launch_Out_Base     (Launch_Out_Base),
      .Launch_In_Len       (Launch_In_Len),
      .Launch_Out_Len      (Launch_Out_Len),
      .In_Data             (In_Data),
      .In_Data_Valid       (In_Data_Valid),
      .In_Data_Ready       (In_Data_Ready),
      .Out_Data            (Out_Data),
      .Out_Data_Valid      (Out_Data_Valid),
      .Out_Data_Ready      (Out_Data_Ready),
      .Bram_En             (Bram_En),
      .Bram_Wen            (Bram_Wen),
      .Bram_Addr           (Bram_Addr),
      .Bram_Data_To_Bram   (Bram_Data_To_Bram),
      .Bram_Data_From_Bram (Bram_Data_From_Bram),
      .Computation_Start   (Computation_Start),
      .Computation_Done    (Computation_Done),
      .Busy                (Busy),
      .Error               (Error),
      .Launch_Done         (Launch_Done)
   );

   int n_vec, n_err, cyc;

   // BRAM contents and per-launch traffic logs
   logic [31:0] mem [logic [31:0]];
   logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], out_q[$], in_words[$], exp_q[$];
   int          bad_bram, bad_busy, unstable, stall_cyc, ld_cnt, err_cnt;
   int          start_hi, start_rise, err_cyc;
   logic        start_at_err, prev_start, prev_vs, in_hs;
   logic [31:0] prev_data, rd_next;

   // Done responder: rises after done_delay Start cycles, falls clr_delay cycles after Start drops
   int          done_delay, clr_delay, start_cyc, low_cyc;
   bit          done_never, done_sticky;
   logic        done_next;

   task automatic clear_logs();
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); out_q.delete();
      bad_bram = 0; bad_busy = 0; unstable = 0; stall_cyc = 0; ld_cnt = 0; err_cnt = 0;
      start_hi = 0; start_rise = -1; err_cyc = -1; start_at_err = 1'b0;
      prev_start = 1'b0; prev_vs = 1'b0; start_cyc = 0; low_cyc = 0;
   endtask

   // Observe at negedge, then apply model-driven inputs just after the next posedge.
   task automatic tick();
      @(negedge Clk);
      cyc++;
      in_hs   = In_Data_Valid && In_Data_Ready;
      rd_next = $urandom;
      if (Bram_En && Bram_Wen == '1) begin
         if (!in_hs) bad_bram++;
         wr_addr_q.push_back(Bram_Addr);
         wr_data_q.push_back(Bram_Data_To_Bram);
         mem[Bram_Addr] = Bram_Data_To_Bram;
      end else if (Bram_En && Bram_Wen == '0) begin
         rd_addr_q.push_back(Bram_Addr);
         rd_next = mem.exists(Bram_Addr) ? mem[Bram_Addr] : 32'h0;
      end else if (Bram_En || Bram_Wen != '0) begin
         bad_bram++;
      end
      if (in_hs && !(Bram_En && Bram_Wen == '1)) bad_bram++;
      if (Busy === Launch_Ready) bad_busy++;
      if (prev_vs && !(Out_Data_Valid === 1'b1 && Out_Data === prev_data)) unstable++;
      if (Out_Data_Valid && !Out_Data_Ready) stall_cyc++;
      if (Out_Data_Valid && Out_Data_Ready) out_q.push_back(Out_Data);
      prev_vs   = Out_Data_Valid && !Out_Data_Ready;
      prev_data = Out_Data;
      if (Computation_Start) begin
         start_hi++;
         if (!prev_start) start_rise = cyc;
      end
      prev_start = Computation_Start;
      if (Error) begin
         err_cnt++; err_cyc = cyc; start_at_err = Computation_Start;
      end
      if (Launch_Done) ld_cnt++;
      if (done_sticky) begin
         done_next = 1'b1;
         if (Computation_Start) done_sticky = 1'b0;
      end else if (Computation_Start) begin
         start_cyc++; low_cyc = 0;
         if (!done_never && start_cyc >= done_delay) done_next = 1'b1;
      end else begin
         start_cyc = 0;
         if (done_next) begin
            low_cyc++;
            if (low_cyc >= clr_delay) begin done_next = 1'b0; low_cyc = 0; end
         end
      end
      @(posedge Clk);
      #1;
      Bram_Data_From_Bram = rd_next;
      Computation_Done    = done_next;
   endtask

   task automatic do_reset();
      Rst = 1'b1; Launch_Valid = 1'b0; In_Data_Valid = 1'b0; Out_Data_Ready = 1'b0;
      done_next = 1'b0; done_sticky = 1'b0; done_never = 1'b0;
      tick(); tick();
      Rst = 1'b0;
      clear_logs();
   endtask

   // Drives one launch to completion (Launch_Done or Error) within a cycle budget.
   task automatic run_launch(input logic [31:0] ib, input logic [31:0] ob, input int il,
                             input int ol, input bit rnd, input int stall);
      int idx, budget;
      idx = 0; budget = 0;
      clear_logs();
      Launch_Valid = 1'b1; Launch_In_Base = ib; Launch_Out_Base = ob;
      Launch_In_Len = LW'(il); Launch_Out_Len = LW'(ol);
      In_Data_Valid = 1'b0; Out_Data_Ready = 1'b0;
      tick();
      while (ld_cnt == 0 && err_cnt == 0 && budget < 400) begin
         Launch_Valid = rnd ? 1'($urandom) : 1'b0;
         if (rnd) begin
            Launch_In_Base = $urandom; Launch_Out_Base = $urandom;
            Launch_In_Len = LW'($urandom); Launch_Out_Len = LW'($urandom);
         end
         In_Data_Valid = (idx < in_words.size()) && (rnd ? ($urandom % 3 != 0) : 1'b1);
         In_Data = (idx < in_words.size()) ? in_words[idx] : $urandom;
         if (Out_Data_Valid && stall > 0) begin
            Out_Data_Ready = 1'b0; stall--;
         end else begin
            Out_Data_Ready = rnd ? 1'($urandom) : 1'b1;
         end
         tick();
         if (in_hs) idx++;
         budget++;
      end
      Launch_Valid = 1'b0; In_Data_Valid = 1'b0; Out_Data_Ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] flags;
      Rst = 1'b1; Launch_Valid = 1'b1; In_Data_Valid = 1'b1; Out_Data_Ready = 1'b1;
      tick(); tick();
      flags = {Launch_Ready, Busy, Computation_Start, Out_Data_Valid, Error, Launch_Done,
               Bram_En, In_Data_Ready};
      n_vec++;
      if (flags !== 8'b1000_0000) begin
         n_err++; $display("FAIL reset_flags: got %b want %b", flags, 8'b1000_0000);
      end
      n_vec++;
      if (Bram_Wen !== 4'h0) begin n_err++; $display("FAIL reset_wen: got %h want 0", Bram_Wen); end
      n_vec++;
      if (Out_Data !== 32'h0) begin n_err++; $display("FAIL reset_odata: got %h want 0", Out_Data); end
      n_vec++;
      if (Bram_Addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", Bram_Addr); end
      Launch_Valid = 1'b0; In_Data_Valid = 1'b0; Out_Data_Ready = 1'b0;
      Rst = 1'b0;
      clear_logs();
   endtask

   task automatic test_load_only();
      logic [31:0] got;
      do_reset();
      in_words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      done_delay = 5; clr_delay = 2;
      run_launch(32'h100, 32'h300, 3, 0, 1'b0, 0);
      n_vec++;
      if (wr_addr_q.size() != 3) begin
         n_err++; $display("FAIL load_wr_count: got %0d want 3", wr_addr_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         got = (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hxxxx_xxxx;
         n_vec++;
         if (got !== 32'h100 + 32'(4 * i)) begin
            n_err++; $display("FAIL load_addr[%0d]: got %h want %h", i, got, 32'h100 + 4 * i);
         end
         got = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxx_xxxx;
         n_vec++;
         if (got !== in_words[i]) begin
            n_err++; $display("FAIL load_data[%0d]: got %h want %h", i, got, in_words[i]);
         end
      end
      n_vec++;
      if (start_hi != 6) begin n_err++; $display("FAIL load_start_cycles: got %0d want 6", start_hi); end
      n_vec++;
      if (ld_cnt != 1 || err_cnt != 0 || rd_addr_q.size() != 0) begin
         n_err++; $display("FAIL load_finish: done %0d err %0d reads %0d want 1 0 0",
                           ld_cnt, err_cnt, rd_addr_q.size());
      end
      n_vec++;
      if (bad_bram != 0 || bad_busy != 0) begin
         n_err++; $display("FAIL load_bus_rules: bram %0d busy %0d want 0 0", bad_bram, bad_busy);
      end
   endtask

   task automatic test_readback_stall();
      logic [31:0] got;
      do_reset();
      in_words.delete();
      mem[32'h200] = 32'h1234_5678; mem[32'h204] = 32'h9ABC_DEF0;
      done_delay = 2; clr_delay = 1;
      run_launch(32'h180, 32'h200, 0, 2, 1'b0, 4);
      for (int i = 0; i < 2; i++) begin
         got = (i < rd_addr_q.size()) ? rd_addr_q[i] : 32'hxxxx_xxxx;
         n_vec++;
         if (got !== 32'h200 + 32'(4 * i)) begin
            n_err++; $display("FAIL rd_addr[%0d]: got %h want %h", i, got, 32'h200 + 4 * i);
         end
      end
      got = (out_q.size() > 0) ? out_q[0] : 32'hxxxx_xxxx;
      n_vec++;
      if (got !== 32'h1234_5678) begin n_err++; $display("FAIL rd_out0: got %h want 12345678", got); end
      got = (out_q.size() > 1) ? out_q[1] : 32'hxxxx_xxxx;
      n_vec++;
      if (got !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL rd_out1: got %h want 9abcdef0", got); end
      n_vec++;
      if (stall_cyc != 4 || unstable != 0) begin
         n_err++; $display("FAIL rd_stall_hold: stall %0d unstable %0d want 4 0", stall_cyc, unstable);
      end
      n_vec++;
      if (ld_cnt != 1 || wr_addr_q.size() != 0) begin
         n_err++; $display("FAIL rd_finish: done %0d writes %0d want 1 0", ld_cnt, wr_addr_q.size());
      end
   endtask

   task automatic test_timeout();
      do_reset();
      in_words.delete();
      done_never = 1'b1;
      run_launch(32'h0, 32'h400, 0, 2, 1'b0, 0);
      n_vec++;
      if (err_cnt != 1 || ld_cnt != 0) begin
         n_err++; $display("FAIL tmo_error: err %0d done %0d want 1 0", err_cnt, ld_cnt);
      end
      // Start rises in the START cycle; WAIT_DONE is entered one cycle later.
      n_vec++;
      if (err_cyc - start_rise != TMO + 1) begin
         n_err++; $display("FAIL tmo_latency: got %0d want %0d", err_cyc - start_rise, TMO + 1);
      end
      n_vec++;
      if (start_at_err !== 1'b0 || start_hi != TMO + 1) begin
         n_err++; $display("FAIL tmo_start: at_err %b cycles %0d want 0 %0d",
                           start_at_err, start_hi, TMO + 1);
      end
      n_vec++;
      if (rd_addr_q.size() != 0 || out_q.size() != 0) begin
         n_err++; $display("FAIL tmo_no_reads: reads %0d outs %0d want 0 0",
                           rd_addr_q.size(), out_q.size());
      end
      n_vec++;
      if (Launch_Ready !== 1'b1 || Computation_Start !== 1'b0) begin
         n_err++; $display("FAIL tmo_idle: ready %b start %b want 1 0", Launch_Ready, Computation_Start);
      end
      done_never = 1'b0;
   endtask

   task automatic test_zero_len();
      do_reset();
      in_words.delete();
      done_delay = 2; clr_delay = 3;
      run_launch(32'h10, 32'h20, 0, 0, 1'b0, 0);
      n_vec++;
      if (wr_addr_q.size() != 0 || rd_addr_q.size() != 0 || bad_bram != 0) begin
         n_err++; $display("FAIL zero_bram: wr %0d rd %0d bad %0d want 0 0 0",
                           wr_addr_q.size(), rd_addr_q.size(), bad_bram);
      end
      n_vec++;
      if (ld_cnt != 1 || start_hi != 3) begin
         n_err++; $display("FAIL zero_finish: done %0d start %0d want 1 3", ld_cnt, start_hi);
      end
   endtask

   task automatic test_already_done();
      do_reset();
      in_words.delete();
      done_sticky = 1'b1; done_next = 1'b1; clr_delay = 1;
      run_launch(32'h10, 32'h20, 0, 0, 1'b0, 0);
      n_vec++;
      if (ld_cnt != 1 || err_cnt != 0 || start_hi != 2) begin
         n_err++; $display("FAIL early_done: done %0d err %0d start %0d want 1 0 2",
                           ld_cnt, err_cnt, start_hi);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] got;
      do_reset();
      done_never = 1'b1;
      Launch_Valid = 1'b1; Launch_In_Base = 32'h0; Launch_Out_Base = 32'h500;
      Launch_In_Len = 16'd0; Launch_Out_Len = 16'd1;
      tick();
      Launch_Valid = 1'b0;
      repeat (5) tick();
      n_vec++;
      if (Computation_Start !== 1'b1) begin
         n_err++; $display("FAIL rstmid_pre: start %b want 1", Computation_Start);
      end
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      n_vec++;
      if (Computation_Start !== 1'b0 || Launch_Ready !== 1'b1 || Out_Data_Valid !== 1'b0) begin
         n_err++; $display("FAIL rstmid_post: start %b ready %b ovalid %b want 0 1 0",
                           Computation_Start, Launch_Ready, Out_Data_Valid);
      end
      done_never = 1'b0; done_delay = 3; clr_delay = 1;
      mem[32'h500] = 32'h5A5A_A5A5;
      in_words = '{32'hDEAD_BEEF};
      run_launch(32'h40, 32'h500, 1, 1, 1'b0, 0);
      got = (out_q.size() > 0) ? out_q[0] : 32'hxxxx_xxxx;
      n_vec++;
      if (ld_cnt != 1 || got !== 32'h5A5A_A5A5) begin
         n_err++; $display("FAIL rstmid_relaunch: done %0d out %h want 1 5a5aa5a5", ld_cnt, got);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a [2];
      logic [31:0] got;
      do_reset();
      exp_a = '{32'hFFFF_FFFC, 32'h0000_0000};
      in_words = '{$urandom, $urandom};
      done_delay = 1; clr_delay = 1;
      run_launch(32'hFFFF_FFFC, 32'hFFFF_FFFC, 2, 2, 1'b0, 0);
      for (int i = 0; i < 2; i++) begin
         got = (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hxxxx_xxxx;
         n_vec++;
         if (got !== exp_a[i]) begin
            n_err++; $display("FAIL wrap_wr[%0d]: got %h want %h", i, got, exp_a[i]);
         end
         got = (i < out_q.size()) ? out_q[i] : 32'hxxxx_xxxx;
         n_vec++;
         if (got !== in_words[i]) begin
            n_err++; $display("FAIL wrap_out[%0d]: got %h want %h", i, got, in_words[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ib, ob, a, e, got;
      int il, ol, exp_start;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         ib = {$urandom_range(0, 255), 2'b00} + 32'h1000;
         ob = {$urandom_range(0, 255), 2'b00} + 32'h1000;
         il = $urandom_range(0, 5); ol = $urandom_range(0, 5);
         done_delay = $urandom_range(0, 4); clr_delay = $urandom_range(0, 3);
         in_words.delete();
         for (int j = 0; j < il; j++) in_words.push_back($urandom);
         for (int i = 0; i < ol; i++) mem[ob + 32'(4 * i)] = $urandom;
         exp_q.delete();
         for (int i = 0; i < ol; i++) begin
            a = ob + 32'(4 * i);
            e = mem[a];
            for (int j = 0; j < il; j++) if (ib + 32'(4 * j) == a) e = in_words[j];
            exp_q.push_back(e);
         end
         exp_start = ((done_delay < 1) ? 1 : done_delay) + 1;
         run_launch(ib, ob, il, ol, 1'b1, 0);
         n_vec++;
         if (wr_addr_q.size() != il || rd_addr_q.size() != ol || out_q.size() != ol) begin
            n_err++; $display("FAIL b2b[%0d]_counts: wr %0d rd %0d out %0d want %0d %0d %0d", k,
                              wr_addr_q.size(), rd_addr_q.size(), out_q.size(), il, ol, ol);
         end
         for (int j = 0; j < il; j++) begin
            got = (j < wr_addr_q.size()) ? wr_addr_q[j] : 32'hxxxx_xxxx;
            e   = (j < wr_data_q.size()) ? wr_data_q[j] : 32'hxxxx_xxxx;
            n_vec++;
            if (got !== ib + 32'(4 * j) || e !== in_words[j]) begin
               n_err++; $display("FAIL b2b[%0d]_wr[%0d]: got %h/%h want %h/%h", k, j, got, e,
                                 ib + 32'(4 * j), in_words[j]);
            end
         end
         for (int i = 0; i < ol; i++) begin
            got = (i < rd_addr_q.size()) ? rd_addr_q[i] : 32'hxxxx_xxxx;
            e   = (i < out_q.size()) ? out_q[i] : 32'hxxxx_xxxx;
            n_vec++;
            if (got !== ob + 32'(4 * i) || e !== exp_q[i]) begin
               n_err++; $display("FAIL b2b[%0d]_rd[%0d]: got %h/%h want %h/%h", k, i, got, e,
                                 ob + 32'(4 * i), exp_q[i]);
            end
         end
         n_vec++;
         if (ld_cnt != 1 || err_cnt != 0 || start_hi != exp_start) begin
            n_err++; $display("FAIL b2b[%0d]_finish: done %0d err %0d start %0d want 1 0 %0d", k,
                              ld_cnt, err_cnt, start_hi, exp_start);
         end
         n_vec++;
         if (bad_bram != 0 || bad_busy != 0 || unstable != 0) begin
            n_err++; $display("FAIL b2b[%0d]_rules: bram %0d busy %0d unstable %0d want 0 0 0", k,
                              bad_bram, bad_busy, unstable);
         end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      Rst = 1'b1; Launch_Valid = 1'b0; Launch_In_Base = '0; Launch_Out_Base = '0;
      Launch_In_Len = '0; Launch_Out_Len = '0; In_Data = '0; In_Data_Valid = 1'b0;
      Out_Data_Ready = 1'b0; Bram_Data_From_Bram = '0; Computation_Done = 1'b0;
      done_delay = 1; clr_delay = 1; done_never = 1'b0; done_sticky = 1'b0; done_next = 1'b0;
      clear_logs();
      test_reset();
      test_load_only();
      test_readback_stall();
      test_timeout();
      test_zero_len();
      test_already_done();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
